nexys_starship_gcd_param: RTL and testbench
===========================================

Name: nexys_starship_gcd_param

Overview:
Parametrised successor to the single-width binary-GCD (Stein) engine used by the Nexys Starship game logic.
- Width is generic. Zero operands are handled explicitly. A fast single-cycle restore mode is optional.
- Adds a coprime flag, a zero-error flag and a step counter.
- Sits under the game top level, driven by its Start/Ack handshake and single-step CEN.

Parameters:
WIDTH, 16, operand and result width (WIDTH >= 2)
CNTW, $clog2(WIDTH)+1, width of i_count (factor-of-2 counter)
CYCW, 16, width of the Cycles step counter
FAST_MULT, 0, 0 = restore one shift per CEN cycle; 1 = restore in a single CEN cycle with a barrel shift by i_count

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
CEN  in  1  step enable for SUB and MULT states
Start  in  1  leave INIT and begin computation
Ack  in  1  acknowledge result, leave DONE
Ain  in  WIDTH  operand A, sampled in INIT
Bin  in  WIDTH  operand B, sampled in INIT
A  out  WIDTH  working register A
B  out  WIDTH  working register B
AB_GCD  out  WIDTH  result register
i_count  out  CNTW  common factors of 2 removed so far
Cycles  out  CYCW  CEN-qualified SUB+MULT steps taken
Coprime  out  1  q_Done & (AB_GCD == 1)
ZeroErr  out  1  registered; set when both operands are 0
q_I, q_Sub, q_Mult, q_Done  out  1 each  one-hot state bits

Behaviour:
- One clock domain (Clk). Reset is asynchronous, active-high.
- Reset values: state = INIT; A, B, AB_GCD, i_count, Cycles = 0; ZeroErr = 0. No X values at reset.
- State register is 4-bit one-hot: INIT=0001, SUB=0010, MULT=0100, DONE=1000. {q_Done,q_Mult,q_Sub,q_I} = state.
- INIT (does not depend on CEN), every cycle:
  - A<=Ain, B<=Bin, AB_GCD<=0, i_count<=0, Cycles<=0, ZeroErr<=0.
  - Start=1 -> SUB next cycle.
- SUB acts only when CEN=1; with CEN=0 all registers hold. On each acting cycle Cycles increments, saturating at all-ones. Actions, in priority order:
  1. A==0 or B==0: AB_GCD<=A|B; ZeroErr<=(A==0 && B==0); -> DONE. Zero is reachable only from the loaded operands.
  2. A==B: AB_GCD<=A; -> DONE if i_count==0, else -> MULT.
  3. A<B: swap A and B.
  4. A>B, both odd: A<=A-B.
  5. A>B, both even: A<=A>>1, B<=B>>1, i_count<=i_count+1.
  6. A>B, mixed parity: halve only the even operand.
- MULT acts only when CEN=1; Cycles increments on each acting cycle.
  - FAST_MULT=0: AB_GCD<=AB_GCD<<1; i_count<=i_count-1; -> DONE when i_count==1.
  - FAST_MULT=1: AB_GCD<=AB_GCD<<i_count; i_count<=0; -> DONE in one cycle.
  - The restored result never exceeds min(Ain,Bin), so it cannot overflow WIDTH.
- DONE:
  - All data registers hold; Coprime is valid.
  - Ack=1 -> INIT. Start is ignored in DONE; if Start and Ack are both high, Ack wins.
- An illegal or non-one-hot state goes to INIT on the next edge. Never UNK or X.
- Reset asserted mid-SUB or mid-MULT aborts immediately to reset values; no partial result survives.
- Latency bound with CEN held high: Cycles <= 6*WIDTH + WIDTH for any nonzero operands.
- Result: AB_GCD = gcd(Ain,Bin), with gcd(0,x)=x and gcd(0,0)=0 plus ZeroErr=1.

Decomposition:
- Shared package nexys_starship_pkg: state localparams (INIT, SUB, MULT, DONE) and a clog2-based CNTW helper.
- Optional sub-module nexys_starship_gcd_step: combinational next-A/B/i_count for the SUB state.
- Everything else stays in one always block with asynchronous reset.

Test Plan:
- WIDTH=16, Ain=36, Bin=24, CEN=1, pulse Start -> i_count peaks at 2, two MULT cycles, AB_GCD=12, Coprime=0, ZeroErr=0; Ack returns to INIT.
- Ain=17, Bin=13 -> AB_GCD=1, Coprime=1, no MULT state visited.
- Ain=0, Bin=45 -> DONE after 1 SUB cycle, AB_GCD=45, ZeroErr=0. Ain=0, Bin=0 -> AB_GCD=0, ZeroErr=1.
- FAST_MULT=1, Ain=1024, Bin=512 -> i_count reaches 9, one MULT cycle, AB_GCD=512.
  - Same stimulus with FAST_MULT=0 -> exactly 9 MULT cycles, same AB_GCD.
- Toggle CEN 1-0-0-1 during SUB -> registers and Cycles frozen while CEN=0; final result unchanged versus CEN=1.
- Assert Reset during MULT -> all outputs 0 and q_I=1 the same cycle. In DONE, Start=Ack=1 -> INIT, not SUB.

Source files
------------

// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship binary-GCD engine:
// one-hot state encodings and the factor-of-2 counter width helper.
package nexys_starship_pkg;

   localparam logic [3:0] INIT = 4'b0001;
   localparam logic [3:0] SUB  = 4'b0010;
   localparam logic [3:0] MULT = 4'b0100;
   localparam logic [3:0] DONE = 4'b1000;

   // Enough bits to count every common factor of 2 a WIDTH-bit operand can hold.
   function automatic int cntw_for(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/nexys_starship_gcd_step.sv
// Combinational reduction step of Stein's algorithm: next A, B and factor-of-2
// count for one SUB cycle, plus the terminal-condition flags.
module nexys_starship_gcd_step
   import nexys_starship_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNTW  = cntw_for(WIDTH)
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [CNTW-1:0]  cnt_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [CNTW-1:0]  cnt_o,
   output logic             zero_o,
   output logic             both_zero_o,
   output logic             equal_o
);

   logic a_even;
   logic b_even;

   assign a_even = ~a_i[0];
   assign b_even = ~b_i[0];

   always_comb begin
      a_o         = a_i;
      b_o         = b_i;
      cnt_o       = cnt_i;
      zero_o      = (a_i == '0) || (b_i == '0);
      both_zero_o = (a_i == '0) && (b_i == '0);
      equal_o     = (a_i == b_i);

      // The caller gives zero and equality priority, so only A != B matters here.
      if (a_i < b_i) begin
         a_o = b_i;
         b_o = a_i;
      end else if (!a_even && !b_even) begin
         a_o = a_i - b_i;
      end else if (a_even && b_even) begin
         a_o   = a_i >> 1;
         b_o   = b_i >> 1;
         cnt_o = cnt_i + CNTW'(1);
      end else if (a_even) begin
         a_o = a_i >> 1;
      end else begin
         b_o = b_i >> 1;
      end
   end

endmodule

// File: rtl/nexys_starship_gcd_param.sv
// Parametrised binary-GCD engine with Start/Ack handshake, CEN single-stepping,
// optional one-cycle power-of-two restore, and coprime/zero-error/step outputs.
module nexys_starship_gcd_param
   import nexys_starship_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int CNTW      = cntw_for(WIDTH),
   parameter int CYCW      = 16,
   parameter bit FAST_MULT = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             CEN,
   input  logic             Start,
   input  logic             Ack,
   input  logic [WIDTH-1:0] Ain,
   input  logic [WIDTH-1:0] Bin,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] AB_GCD,
   output logic [CNTW-1:0]  i_count,
   output logic [CYCW-1:0]  Cycles,
   output logic             Coprime,
   output logic             ZeroErr,
   output logic             q_I,
   output logic             q_Sub,
   output logic             q_Mult,
   output logic             q_Done
);

   logic [3:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [CYCW-1:0]  cyc_q, cyc_d;
   logic             zerr_q, zerr_d;

   logic [WIDTH-1:0] step_a;
   logic [WIDTH-1:0] step_b;
   logic [CNTW-1:0]  step_cnt;
   logic             step_zero;
   logic             step_both_zero;
   logic             step_equal;
   logic [CYCW-1:0]  cyc_inc;

   nexys_starship_gcd_step #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
   ) u_step (
      .a_i         (a_q),
      .b_i         (b_q),
      .cnt_i       (cnt_q),
      .a_o         (step_a),
      .b_o         (step_b),
      .cnt_o       (step_cnt),
      .zero_o      (step_zero),
      .both_zero_o (step_both_zero),
      .equal_o     (step_equal)
   );

   // Step counter saturates rather than wrapping so long runs stay monotonic.
   assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CYCW'(1);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      gcd_d   = gcd_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      zerr_d  = zerr_q;

      case (state_q)
         INIT: begin
            a_d    = Ain;
            b_d    = Bin;
            gcd_d  = '0;
            cnt_d  = '0;
            cyc_d  = '0;
            zerr_d = 1'b0;
            if (Start) begin
               state_d = SUB;
            end
         end

         SUB: begin
            if (CEN) begin
               cyc_d = cyc_inc;
               if (step_zero) begin
                  gcd_d   = a_q | b_q;
                  zerr_d  = step_both_zero;
                  state_d = DONE;
               end else if (step_equal) begin
                  gcd_d   = a_q;
                  state_d = (cnt_q == '0) ? DONE : MULT;
               end else begin
                  a_d   = step_a;
                  b_d   = step_b;
                  cnt_d = step_cnt;
               end
            end
         end

         MULT: begin
            if (CEN) begin
               cyc_d = cyc_inc;
               if (FAST_MULT) begin
                  gcd_d   = gcd_q << cnt_q;
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  gcd_d = gcd_q << 1;
                  cnt_d = cnt_q - CNTW'(1);
                  // <= 1 rather than == 1 so a corrupted zero count cannot wrap forever.
                  if (cnt_q <= CNTW'(1)) begin
                     state_d = DONE;
                  end
               end
            end
         end

         DONE: begin
            if (Ack) begin
               state_d = INIT;
            end
         end

         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= INIT;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
         cnt_q   <= '0;
         cyc_q   <= '0;
         zerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         zerr_q  <= zerr_d;
      end
   end

   assign {q_Done, q_Mult, q_Sub, q_I} = state_q;

   assign A       = a_q;
   assign B       = b_q;
   assign AB_GCD  = gcd_q;
   assign i_count = cnt_q;
   assign Cycles  = cyc_q;
   assign ZeroErr = zerr_q;
   assign Coprime = q_Done & (gcd_q == WIDTH'(1));

endmodule

// File: tb/tb_nexys_starship_gcd_param.sv
// Scoreboard bench: a slow-restore and a fast-restore engine share stimulus;
// monitors pop expected results whenever either engine enters DONE.
module tb_nexys_starship_gcd_param;

   localparam int W  = 16;
   localparam int CW = 5;
   localparam int YW = 16;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          CEN;
   logic          Start;
   logic          Ack;
   logic [W-1:0]  Ain;
   logic [W-1:0]  Bin;

   logic [W-1:0]  s_A, s_B, s_gcd;
   logic [CW-1:0] s_cnt;
   logic [YW-1:0] s_cyc;
   logic          s_cop, s_zerr, s_qI, s_qSub, s_qMult, s_qDone;

   logic [W-1:0]  f_A, f_B, f_gcd;
   logic [CW-1:0] f_cnt;
   logic [YW-1:0] f_cyc;
   logic          f_cop, f_zerr, f_qI, f_qSub, f_qMult, f_qDone;

   always #5 Clk = ~Clk;

   nexys_starship_gcd_param #(
      .WIDTH (W), .CNTW (CW), .CYCW (YW), .FAST_MULT (1'b0)
   ) u_slow (
      .Clk (Clk), .Reset (Reset), .CEN (CEN), .Start (Start), .Ack (Ack),
      .Ain (Ain), .Bin (Bin), .A (s_A), .B (s_B), .AB_GCD (s_gcd),
      .i_count (s_cnt), .Cycles (s_cyc), .Coprime (s_cop), .ZeroErr (s_zerr),
      .q_I (s_qI), .q_Sub (s_qSub), .q_Mult (s_qMult), .q_Done (s_qDone)
   );

   nexys_starship_gcd_param #(
      .WIDTH (W), .CNTW (CW), .CYCW (YW), .FAST_MULT (1'b1)
   ) u_fast (
      .Clk (Clk), .Reset (Reset), .CEN (CEN), .Start (Start), .Ack (Ack),
      .Ain (Ain), .Bin (Bin), .A (f_A), .B (f_B), .AB_GCD (f_gcd),
      .i_count (f_cnt), .Cycles (f_cyc), .Coprime (f_cop), .ZeroErr (f_zerr),
      .q_I (f_qI), .q_Sub (f_qSub), .q_Mult (f_qMult), .q_Done (f_qDone)
   );

   typedef struct {
      logic [W-1:0]  gcd;
      logic          zerr;
      logic          cop;
      logic [YW-1:0] cyc;
      int            mults;
   } exp_t;

   exp_t q_s[$];
   exp_t q_f[$];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic score(input string t, input exp_t e, input logic [W-1:0] g,
                        input logic z, input logic c, input logic [YW-1:0] cy,
                        input int m);
      check({t, "_gcd"}, g, e.gcd);
      check({t, "_zeroerr"}, z, e.zerr);
      check({t, "_coprime"}, c, e.cop);
      check({t, "_cycles"}, cy, e.cyc);
      check({t, "_mult_cycles"}, m, e.mults);
      $display("%s done: gcd=%0d zerr=%0d coprime=%0d cycles=%0d mults=%0d",
               t, g, z, c, cy, m);
   endtask

   // Slow-restore monitor
   logic s_prev = 1'b0;
   int   s_mults = 0;
   exp_t s_e;
   initial begin
      forever begin
         @(negedge Clk);
         if (Reset || s_qI) s_mults = 0;
         else if (s_qMult && CEN) s_mults++;
         if (s_qDone && !s_prev && !Reset) begin
            check("slow_queue_has_entry", q_s.size() > 0, 1);
            if (q_s.size() > 0) begin
               s_e = q_s.pop_front();
               score("slow", s_e, s_gcd, s_zerr, s_cop, s_cyc, s_mults);
            end
         end
         s_prev = s_qDone;
      end
   end

   // Fast-restore monitor
   logic f_prev = 1'b0;
   int   f_mults = 0;
   exp_t f_e;
   initial begin
      forever begin
         @(negedge Clk);
         if (Reset || f_qI) f_mults = 0;
         else if (f_qMult && CEN) f_mults++;
         if (f_qDone && !f_prev && !Reset) begin
            check("fast_queue_has_entry", q_f.size() > 0, 1);
            if (q_f.size() > 0) begin
               f_e = q_f.pop_front();
               score("fast", f_e, f_gcd, f_zerr, f_cop, f_cyc, f_mults);
            end
         end
         f_prev = f_qDone;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic expect_txn(input logic [W-1:0] g, input logic z,
                             input logic [YW-1:0] cs, input logic [YW-1:0] cf,
                             input int ms, input int mf);
      exp_t e;
      e.gcd   = g;
      e.zerr  = z;
      e.cop   = (g == 16'd1);
      e.cyc   = cs;
      e.mults = ms;
      q_s.push_back(e);
      e.cyc   = cf;
      e.mults = mf;
      q_f.push_back(e);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400; i++) begin
         if (s_qDone && f_qDone) break;
         tick();
      end
      check("done_within_bound", s_qDone && f_qDone, 1);
   endtask

   // Load operands, pulse Start, wait for both engines, then acknowledge.
   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] g, input logic z,
                      input logic [YW-1:0] cs, input logic [YW-1:0] cf,
                      input int ms, input int mf, input bit start_with_ack);
      Ain = a;
      Bin = b;
      expect_txn(g, z, cs, cf, ms, mf);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_done();
      tick();
      Ack = 1'b1;
      if (start_with_ack) Start = 1'b1;
      tick();
      Ack   = 1'b0;
      Start = 1'b0;
      check("ack_to_init", s_qI, 1);
      check("ack_not_sub", s_qSub, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1;
      CEN   = 1'b1;
      Start = 1'b0;
      Ack   = 1'b0;
      Ain   = 16'd99;
      Bin   = 16'd77;
      tick();
      tick();
      check("rst_q_I", s_qI, 1);
      check("rst_state_others", {s_qSub, s_qMult, s_qDone}, 0);
      check("rst_A", s_A, 0);
      check("rst_B", s_B, 0);
      check("rst_gcd", s_gcd, 0);
      check("rst_i_count", s_cnt, 0);
      check("rst_cycles", s_cyc, 0);
      check("rst_zeroerr", s_zerr, 0);
      check("rst_coprime", s_cop, 0);
      Reset = 1'b0;
      tick();

      //   a      b      gcd  zerr slowcyc fastcyc slowmult fastmult
      run(16'd36,   16'd24,  16'd12,  1'b0, 16'd8,  16'd7,  2, 1, 1'b0);
      run(16'd17,   16'd13,  16'd1,   1'b0, 16'd10, 16'd10, 0, 0, 1'b0);
      run(16'd0,    16'd45,  16'd45,  1'b0, 16'd1,  16'd1,  0, 0, 1'b0);
      run(16'd45,   16'd0,   16'd45,  1'b0, 16'd1,  16'd1,  0, 0, 1'b0);
      run(16'd0,    16'd0,   16'd0,   1'b1, 16'd1,  16'd1,  0, 0, 1'b0);
      run(16'd1024, 16'd512, 16'd512, 1'b0, 16'd20, 16'd12, 9, 1, 1'b0);
      run(16'd48,   16'd18,  16'd6,   1'b0, 16'd9,  16'd9,  1, 1, 1'b0);
      run(16'd7,    16'd7,   16'd7,   1'b0, 16'd1,  16'd1,  0, 0, 1'b1);

      // CEN single-step: one acting cycle, two frozen cycles, then run on.
      Ain = 16'd36;
      Bin = 16'd24;
      expect_txn(16'd12, 1'b0, 16'd8, 16'd7, 2, 1);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      CEN = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("cen_hold_A", s_A, 18);
         check("cen_hold_B", s_B, 12);
         check("cen_hold_i_count", s_cnt, 1);
         check("cen_hold_cycles", s_cyc, 1);
         check("cen_hold_fast_cycles", f_cyc, 1);
      end
      CEN = 1'b1;
      wait_done();
      tick();
      Ack = 1'b1;
      tick();
      Ack = 1'b0;

      // Asynchronous reset while restoring factors of two.
      Ain = 16'd1024;
      Bin = 16'd512;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (s_qMult) break;
         tick();
      end
      check("abort_reached_mult", s_qMult, 1);
      check("abort_i_count_peak", s_cnt, 9);
      #2;
      Reset = 1'b1;
      #1;
      check("abort_q_I", s_qI, 1);
      check("abort_q_Mult", s_qMult, 0);
      check("abort_A", s_A, 0);
      check("abort_B", s_B, 0);
      check("abort_gcd", s_gcd, 0);
      check("abort_i_count", s_cnt, 0);
      check("abort_cycles", s_cyc, 0);
      check("abort_fast_q_I", f_qI, 1);
      $display("abort: q_I=%0d A=%0d gcd=%0d cycles=%0d", s_qI, s_A, s_gcd, s_cyc);
      tick();
      Reset = 1'b0;
      tick();
      tick();
      check("abort_stays_init", s_qI, 1);

      check("slow_queue_drained", q_s.size(), 0);
      check("fast_queue_drained", q_f.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
